// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data word, RAM handshake state and the arbiter FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IREQ = 2'd1,
    DREQ = 2'd2,
    ERR  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Saturating wait-cycle counter; expired_o flags the increment that reaches TIMEOUT.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CMAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Combinational so the FSM can leave on the very cycle the limit is reached.
  assign expired_o = inc_i && !clr_i && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction and data requests onto one wait-stated RAM port; sticky err on RAM error/timeout.
// Optional MEM_ARBITER_STATS_EN adds saturating hit/wait statistics outputs.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT       = 64,
  parameter bit          DATA_PRIORITY = 1'b1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      ihit,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dhit,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
`ifdef MEM_ARBITER_STATS_EN
  ,
  output word_t     stat_ifetch,
  output word_t     stat_dacc,
  output word_t     stat_wait
`endif
);

  arb_state_t state_q, state_d;
  logic dreq, granted, wait_cyc, abort;
  logic tmo_clr, tmo_exp;

  assign dreq     = dREN | dWEN;
  assign granted  = (state_q == IREQ) || (state_q == DREQ);
  assign wait_cyc = granted && (ramstate != ACCESS);
  assign abort    = ((state_q == IREQ) && !iREN) || ((state_q == DREQ) && !dreq);
  assign tmo_clr  = ihit || dhit || abort;
  assign err      = (state_q == ERR);

  mem_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i    (CLK),
    .rst_i    (RST),
    .inc_i    (wait_cyc),
    .clr_i    (tmo_clr),
    .expired_o(tmo_exp)
  );

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    case (state_q)
      IDLE: begin
        if (dreq && (DATA_PRIORITY || !iREN)) begin
          state_d = DREQ;
        end else if (iREN) begin
          state_d = IREQ;
        end
      end
      IREQ: begin
        // Enables follow the live request so a dropped request aborts in the same cycle.
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ERROR) begin
          state_d = ERR;
        end else if (ramstate == ACCESS) begin
          ihit    = 1'b1;
          iload   = ramload;
          state_d = dreq ? DREQ : IDLE;
        end else if (tmo_exp) begin
          state_d = ERR;
        end
      end
      DREQ: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          state_d = IDLE;
        end else if (ramstate == ERROR) begin
          state_d = ERR;
        end else if (ramstate == ACCESS) begin
          dhit    = 1'b1;
          dload   = ramload;
          state_d = iREN ? IREQ : IDLE;
        end else if (tmo_exp) begin
          state_d = ERR;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  word_t ifetch_q, dacc_q, wait_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ifetch_q <= '0;
      dacc_q   <= '0;
      wait_q   <= '0;
    end else begin
      if (ihit && (ifetch_q != '1)) ifetch_q <= ifetch_q + 32'd1;
      if (dhit && (dacc_q != '1))   dacc_q   <= dacc_q + 32'd1;
      if (wait_cyc && (wait_q != '1)) wait_q <= wait_q + 32'd1;
    end
  end

  assign stat_ifetch = ifetch_q;
  assign stat_dacc   = dacc_q;
  assign stat_wait   = wait_q;
`endif

endmodule
